// File: rtl/sudoku_mask_iter.sv
// sudoku_mask_iter: one candidate-elimination pass per clock until stable.
// Optional box/line pointing rule is compiled in with SUDOKU_POINTING_EN.
module sudoku_mask_iter #(
  parameter int BOX      = 3,
  parameter int MAX_ITER = 32,
  parameter int CNT_W    = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [BOX*BOX*BOX*BOX*BOX*BOX-1:0] mask_in,
  output logic [BOX*BOX*BOX*BOX*BOX*BOX-1:0] mask_out,
  output logic                               busy,
  output logic                               done,
  output logic                               solved,
  output logic                               conflict,
  output logic [CNT_W-1:0]                   iter_count
);

  localparam int SIDE = BOX * BOX;
  localparam int MW   = SIDE * SIDE * SIDE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mask_d;
  logic [CNT_W-1:0] cnt_d;
  logic             solved_d, conflict_d;

  logic [SIDE-1:0] cand [SIDE][SIDE];
  logic [SIDE-1:0] one  [SIDE][SIDE];
  logic            lone [SIDE][SIDE];
  logic [SIDE-1:0] row_any [SIDE];
  logic [SIDE-1:0] row_dup [SIDE];
  logic [SIDE-1:0] col_any [SIDE];
  logic [SIDE-1:0] col_dup [SIDE];
  logic [SIDE-1:0] box_any [SIDE];
  logic [SIDE-1:0] box_dup [SIDE];
  logic [SIDE-1:0] peer;
  logic [MW-1:0]   elim;
  logic [MW-1:0]   pass_m;
  logic            any_empty;
  logic            all_lone;

  // Per-cell candidate sets, single-candidate detection, global flags
  always_comb begin
    any_empty = 1'b0;
    all_lone  = 1'b1;
    for (int x = 0; x < SIDE; x++) begin
      for (int y = 0; y < SIDE; y++) begin
        cand[x][y] = ~mask_out[(x*SIDE+y)*SIDE +: SIDE];
        lone[x][y] = (cand[x][y] != '0) &&
                     ((cand[x][y] & (cand[x][y] - SIDE'(1))) == '0);
        one[x][y]  = lone[x][y] ? cand[x][y] : '0;
        any_empty  = any_empty | (cand[x][y] == '0);
        all_lone   = all_lone & lone[x][y];
      end
    end
  end

  // Which digits are held by singles per unit, and which by two or more
  always_comb begin
    for (int i = 0; i < SIDE; i++) begin
      row_any[i] = '0;
      row_dup[i] = '0;
      col_any[i] = '0;
      col_dup[i] = '0;
      box_any[i] = '0;
      box_dup[i] = '0;
    end
    for (int x = 0; x < SIDE; x++) begin
      for (int y = 0; y < SIDE; y++) begin
        row_dup[y] = row_dup[y] | (row_any[y] & one[x][y]);
        row_any[y] = row_any[y] | one[x][y];
        col_dup[x] = col_dup[x] | (col_any[x] & one[x][y]);
        col_any[x] = col_any[x] | one[x][y];
        box_dup[(y/BOX)*BOX+x/BOX] = box_dup[(y/BOX)*BOX+x/BOX] |
          (box_any[(y/BOX)*BOX+x/BOX] & one[x][y]);
        box_any[(y/BOX)*BOX+x/BOX] = box_any[(y/BOX)*BOX+x/BOX] |
          one[x][y];
      end
    end
  end

`ifdef SUDOKU_POINTING_EN
  logic [SIDE-1:0] ptr_row [SIDE][BOX];
  logic [SIDE-1:0] ptr_col [SIDE][BOX];
  logic [SIDE-1:0] rh [BOX];
  logic [SIDE-1:0] ch [BOX];
  int              nr, nc;

  // Digits confined to a single row / column inside each box
  always_comb begin
    nr = 0;
    nc = 0;
    for (int b = 0; b < SIDE; b++) begin
      for (int k = 0; k < BOX; k++) begin
        rh[k] = '0;
        ch[k] = '0;
      end
      for (int r = 0; r < BOX; r++) begin
        for (int c = 0; c < BOX; c++) begin
          rh[r] = rh[r] | cand[(b%BOX)*BOX+c][(b/BOX)*BOX+r];
          ch[c] = ch[c] | cand[(b%BOX)*BOX+c][(b/BOX)*BOX+r];
        end
      end
      for (int d = 0; d < SIDE; d++) begin
        nr = 0;
        nc = 0;
        for (int k = 0; k < BOX; k++) begin
          if (rh[k][d]) nr++;
          if (ch[k][d]) nc++;
        end
        for (int k = 0; k < BOX; k++) begin
          ptr_row[b][k][d] = rh[k][d] && (nr == 1);
          ptr_col[b][k][d] = ch[k][d] && (nc == 1);
        end
      end
    end
  end
`endif

  // Eliminations for every cell; a cell's own single only counts if duplicated
  always_comb begin
    elim = '0;
    peer = '0;
    for (int x = 0; x < SIDE; x++) begin
      for (int y = 0; y < SIDE; y++) begin
        peer = (one[x][y] & row_dup[y]) | (~one[x][y] & row_any[y]) |
               (one[x][y] & col_dup[x]) | (~one[x][y] & col_any[x]) |
               (one[x][y] & box_dup[(y/BOX)*BOX+x/BOX]) |
               (~one[x][y] & box_any[(y/BOX)*BOX+x/BOX]);
`ifdef SUDOKU_POINTING_EN
        for (int k = 0; k < BOX; k++) begin
          if (k != x / BOX)
            peer = peer | ptr_row[(y/BOX)*BOX+k][y%BOX];
          if (k != y / BOX)
            peer = peer | ptr_col[k*BOX+x/BOX][x%BOX];
        end
`endif
        elim[(x*SIDE+y)*SIDE +: SIDE] = peer;
      end
    end
  end

  assign pass_m = mask_out | elim;

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_out;
    cnt_d      = iter_count;
    solved_d   = solved;
    conflict_d = conflict;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          mask_d     = mask_in;
          cnt_d      = '0;
          solved_d   = 1'b0;
          conflict_d = 1'b0;
        end
      end
      S_RUN: begin
        if (any_empty || (pass_m == mask_out) ||
            (iter_count == CNT_W'(MAX_ITER))) begin
          state_d    = S_DONE;
          conflict_d = any_empty;
          solved_d   = all_lone & ~any_empty;
        end else begin
          mask_d = pass_m;
          cnt_d  = iter_count + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mask_out   <= '0;
      iter_count <= '0;
      solved     <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_out   <= mask_d;
      iter_count <= cnt_d;
      solved     <= solved_d;
      conflict   <= conflict_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_sudoku_mask_iter.sv
// tb_sudoku_mask_iter: randomized and directed checks against a
// cell/peer reference model; pointing model follows SUDOKU_POINTING_EN.
module tb_sudoku_mask_iter;

  localparam int SIDE = 9;
  localparam int MW   = 729;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start0, start1;
  logic [MW-1:0] min0, min1, mo0, mo1;
  logic          busy0, busy1, done0, done1;
  logic          sol0, sol1, conf0, conf1;
  logic [5:0]    cnt0, cnt1;

  int n_chk  = 0;
  int n_fail = 0;
  int grid [SIDE][SIDE];

  always #5 clk = ~clk;

  sudoku_mask_iter #(.BOX(3), .MAX_ITER(32), .CNT_W(6)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mask_in(min0),
    .mask_out(mo0), .busy(busy0), .done(done0), .solved(sol0),
    .conflict(conf0), .iter_count(cnt0)
  );

  sudoku_mask_iter #(.BOX(3), .MAX_ITER(1), .CNT_W(6)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mask_in(min1),
    .mask_out(mo1), .busy(busy1), .done(done1), .solved(sol1),
    .conflict(conf1), .iter_count(cnt1)
  );

  function automatic int idx(int x, int y, int d);
    return (x * SIDE + y) * SIDE + d;
  endfunction

  function automatic int n_open(logic [MW-1:0] m, int x, int y);
    int n = 0;
    for (int d = 0; d < SIDE; d++) if (!m[idx(x, y, d)]) n++;
    return n;
  endfunction

  function automatic bit same_box(int x, int y, int px, int py);
    return (x / 3 == px / 3) && (y / 3 == py / 3);
  endfunction

  function automatic logic [MW-1:0] model_pass(logic [MW-1:0] m);
    logic [MW-1:0] r = m;
    int e;
    for (int x = 0; x < SIDE; x++)
      for (int y = 0; y < SIDE; y++)
        if (n_open(m, x, y) == 1) begin
          e = 0;
          for (int d = 0; d < SIDE; d++) if (!m[idx(x, y, d)]) e = d;
          for (int px = 0; px < SIDE; px++)
            for (int py = 0; py < SIDE; py++)
              if ((px != x || py != y) &&
                  (px == x || py == y || same_box(x, y, px, py)))
                r[idx(px, py, e)] = 1'b1;
        end
`ifdef SUDOKU_POINTING_EN
    for (int bx = 0; bx < 3; bx++)
      for (int by = 0; by < 3; by++)
        for (int d = 0; d < SIDE; d++) begin
          int rsel = -1, csel = -1;
          bit rmul = 0, cmul = 0;
          for (int xx = bx * 3; xx < bx * 3 + 3; xx++)
            for (int yy = by * 3; yy < by * 3 + 3; yy++)
              if (!m[idx(xx, yy, d)]) begin
                if (rsel < 0) rsel = yy; else if (rsel != yy) rmul = 1;
                if (csel < 0) csel = xx; else if (csel != xx) cmul = 1;
              end
          if (rsel >= 0 && !rmul)
            for (int xx = 0; xx < SIDE; xx++)
              if (xx / 3 != bx) r[idx(xx, rsel, d)] = 1'b1;
          if (csel >= 0 && !cmul)
            for (int yy = 0; yy < SIDE; yy++)
              if (yy / 3 != by) r[idx(csel, yy, d)] = 1'b1;
        end
`endif
    return r;
  endfunction

  function automatic void model_run(input logic [MW-1:0] m0,
                                    input int maxit,
                                    output logic [MW-1:0] mf,
                                    output int it, output bit sol,
                                    output bit conf);
    logic [MW-1:0] m = m0, p;
    bit all1;
    it = 0;
    while (1) begin
      conf = 0;
      all1 = 1;
      for (int x = 0; x < SIDE; x++)
        for (int y = 0; y < SIDE; y++) begin
          if (n_open(m, x, y) == 0) conf = 1;
          if (n_open(m, x, y) != 1) all1 = 0;
        end
      p = model_pass(m);
      if (conf || p == m || it == maxit) break;
      m = p;
      it++;
    end
    mf  = m;
    sol = all1 && !conf;
  endfunction

  task automatic make_grid();
    int perm [SIDE];
    int j, t;
    for (int i = 0; i < SIDE; i++) perm[i] = i;
    for (int i = SIDE - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int x = 0; x < SIDE; x++)
      for (int y = 0; y < SIDE; y++)
        grid[x][y] = perm[(y * 3 + y / 3 + x) % SIDE];
  endtask

  function automatic logic [MW-1:0] grid_mask();
    logic [MW-1:0] m = '1;
    for (int x = 0; x < SIDE; x++)
      for (int y = 0; y < SIDE; y++) m[idx(x, y, grid[x][y])] = 1'b0;
    return m;
  endfunction

  function automatic logic [MW-1:0] chain_mask();
    logic [MW-1:0] m = '0;
    for (int d = 0; d < SIDE; d++) begin
      m[idx(0, 8, d)] = (d != 1);
      m[idx(0, 0, d)] = (d != 0 && d != 1);
      m[idx(4, 0, d)] = (d != 0 && d != 2);
      m[idx(4, 5, d)] = (d != 2 && d != 3);
    end
    return m;
  endfunction

  task automatic do_run(input int which, input logic [MW-1:0] m,
                        input bit hold, output int cyc,
                        output logic bsy, output logic [MW-1:0] mo,
                        output logic [5:0] it, output logic sol,
                        output logic conf);
    @(negedge clk);
    if (which == 0) begin start0 = 1'b1; min0 = m; end
    else begin start1 = 1'b1; min1 = m; end
    @(posedge clk); #1;
    bsy = which ? busy1 : busy0;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    else begin min0 = ~m; min1 = ~m; end
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if ((which ? done1 : done0) === 1'b1) begin cyc = c; break; end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    mo   = which ? mo1 : mo0;
    it   = which ? cnt1 : cnt0;
    sol  = which ? sol1 : sol0;
    conf = which ? conf1 : conf0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; min0 = '1; min1 = '1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (mo0 !== '0) begin n_fail++; $display("FAIL rst_mask: got %h want 0", mo0); end
    n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy0); end
    n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done0); end
    n_chk++; if (sol0 !== 1'b0) begin n_fail++; $display("FAIL rst_solved: got %b want 0", sol0); end
    n_chk++; if (conf0 !== 1'b0) begin n_fail++; $display("FAIL rst_conflict: got %b want 0", conf0); end
    n_chk++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL rst_iter: got %0d want 0", cnt0); end
    n_chk++; if (mo1 !== '0 || busy1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL rst_u1: got mask/busy/done nonzero %b %b", busy1, done1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_empty();
    int cyc; logic b, s, c; logic [MW-1:0] mo; logic [5:0] it;
    do_run(0, '0, 0, cyc, b, mo, it, s, c);
    n_chk++; if (b !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b want 1", b); end
    n_chk++; if (cyc != 1) begin n_fail++; $display("FAIL empty_latency: got %0d want 1", cyc); end
    n_chk++; if (it !== 6'd0) begin n_fail++; $display("FAIL empty_iter: got %0d want 0", it); end
    n_chk++; if (s !== 1'b0 || c !== 1'b0) begin n_fail++; $display("FAIL empty_flags: got %b%b want 00", s, c); end
    n_chk++; if (mo !== '0) begin n_fail++; $display("FAIL empty_mask: got %h want 0", mo); end
  endtask

  task automatic test_solved();
    int cyc; logic b, s, c; logic [MW-1:0] mo, gm; logic [5:0] it;
    make_grid();
    gm = grid_mask();
    do_run(0, gm, 0, cyc, b, mo, it, s, c);
    n_chk++; if (it !== 6'd0 || cyc != 1) begin n_fail++; $display("FAIL solved_iter: got %0d/%0d want 0/1", it, cyc); end
    n_chk++; if (s !== 1'b1 || c !== 1'b0) begin n_fail++; $display("FAIL solved_flags: got %b%b want 10", s, c); end
    n_chk++; if (mo !== gm) begin n_fail++; $display("FAIL solved_mask: got %h want %h", mo, gm); end
  endtask

  task automatic test_single_open();
    int cyc; logic b, s, c; logic [MW-1:0] mo, gm, m; logic [5:0] it;
    make_grid();
    gm = grid_mask();
    m = gm;
    for (int d = 0; d < SIDE; d++) m[idx(0, 0, d)] = 1'b0;
    do_run(0, m, 0, cyc, b, mo, it, s, c);
    n_chk++; if (it !== 6'd1 || cyc != 2) begin n_fail++; $display("FAIL open1_iter: got %0d/%0d want 1/2", it, cyc); end
    n_chk++; if (s !== 1'b1 || c !== 1'b0) begin n_fail++; $display("FAIL open1_flags: got %b%b want 10", s, c); end
    n_chk++; if (mo !== gm) begin n_fail++; $display("FAIL open1_mask: got %h want %h", mo, gm); end
  endtask

  task automatic test_row_conflict();
    int cyc, eit; bit es, ec; logic b, s, c; logic [5:0] it;
    logic [MW-1:0] mo, m, em;
    m = '0;
    for (int d = 0; d < SIDE; d++) begin
      m[idx(0, 0, d)] = (d != 5);
      m[idx(1, 0, d)] = (d != 5);
    end
    model_run(m, 32, em, eit, es, ec);
    do_run(0, m, 0, cyc, b, mo, it, s, c);
    n_chk++; if (c !== 1'b1 || s !== 1'b0) begin n_fail++; $display("FAIL conf_flags: got %b%b want 01", s, c); end
    n_chk++; if (it !== 6'd1 || cyc != 2) begin n_fail++; $display("FAIL conf_iter: got %0d/%0d want 1/2", it, cyc); end
    n_chk++; if (mo[idx(0, 0, 5)] !== 1'b1 || mo[idx(1, 0, 5)] !== 1'b1) begin n_fail++; $display("FAIL conf_bits: got %b%b want 11", mo[idx(0, 0, 5)], mo[idx(1, 0, 5)]); end
    n_chk++; if (mo !== em) begin n_fail++; $display("FAIL conf_mask: got %h want %h", mo, em); end
  endtask

  task automatic test_chain_cap();
    int cyc, eit; bit es, ec; logic b, s, c; logic [5:0] it;
    logic [MW-1:0] mo, em;
    model_run(chain_mask(), 1, em, eit, es, ec);
    do_run(1, chain_mask(), 0, cyc, b, mo, it, s, c);
    n_chk++; if (it !== 6'd1 || cyc != 2) begin n_fail++; $display("FAIL cap_iter: got %0d/%0d want 1/2", it, cyc); end
    n_chk++; if (s !== 1'b0 || c !== 1'b0) begin n_fail++; $display("FAIL cap_flags: got %b%b want 00", s, c); end
    n_chk++; if (mo !== em) begin n_fail++; $display("FAIL cap_mask: got %h want %h", mo, em); end
    model_run(chain_mask(), 32, em, eit, es, ec);
    do_run(0, chain_mask(), 0, cyc, b, mo, it, s, c);
    n_chk++; if (it !== 6'(eit) || cyc != eit + 1) begin n_fail++; $display("FAIL chain_iter: got %0d/%0d want %0d", it, cyc, eit); end
    n_chk++; if (mo !== em || s !== es || c !== ec) begin n_fail++; $display("FAIL chain_result: got %h %b%b want %h %b%b", mo, s, c, em, es, ec); end
  endtask

  task automatic test_midrun_reset();
    bit seen = 0;
    @(negedge clk); start0 = 1'b1; min0 = chain_mask();
    @(posedge clk); #1; start0 = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy0); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (mo0 !== '0 || cnt0 !== 6'd0) begin n_fail++; $display("FAIL mid_regs: got iter %0d mask nonzero", cnt0); end
    n_chk++; if ({busy0, done0, sol0, conf0} !== 4'b0) begin n_fail++; $display("FAIL mid_flags: got %b want 0000", {busy0, done0, sol0, conf0}); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL mid_nodone: got activity after abort want none"); end
  endtask

  task automatic test_pointing();
    int cyc, eit; bit es, ec; logic b, s, c; logic [5:0] it;
    logic [MW-1:0] mo, m, em;
    int want_it;
    logic want_bit;
`ifdef SUDOKU_POINTING_EN
    want_it = 1; want_bit = 1'b1;
`else
    want_it = 0; want_bit = 1'b0;
`endif
    m = '0;
    for (int x = 0; x < 3; x++) begin
      m[idx(x, 1, 1)] = 1'b1;
      m[idx(x, 2, 1)] = 1'b1;
    end
    model_run(m, 32, em, eit, es, ec);
    do_run(0, m, 0, cyc, b, mo, it, s, c);
    n_chk++; if (it !== 6'(want_it)) begin n_fail++; $display("FAIL point_iter: got %0d want %0d", it, want_it); end
    n_chk++; if (mo[idx(5, 0, 1)] !== want_bit || mo[idx(8, 0, 1)] !== want_bit) begin n_fail++; $display("FAIL point_bits: got %b%b want %b", mo[idx(5, 0, 1)], mo[idx(8, 0, 1)], want_bit); end
    n_chk++; if (mo[idx(0, 0, 1)] !== 1'b0 || s !== 1'b0 || c !== 1'b0) begin n_fail++; $display("FAIL point_keep: got %b %b%b want 0 00", mo[idx(0, 0, 1)], s, c); end
    n_chk++; if (mo !== em) begin n_fail++; $display("FAIL point_mask: got %h want %h", mo, em); end
  endtask

  task automatic test_random();
    int cyc, eit, w, xx, yy; bit es, ec; logic b, s, c; logic [5:0] it;
    logic [MW-1:0] mo, m, em;
    logic [8:0] r9;
    for (int k = 0; k < 16; k++) begin
      make_grid();
      m = grid_mask();
      for (int x = 0; x < SIDE; x++)
        for (int y = 0; y < SIDE; y++)
          if ($urandom_range(0, 2) == 0) begin
            r9 = 9'($urandom);
            r9[grid[x][y]] = 1'b0;
            m[idx(x, y, 0) +: 9] = r9;
          end
      if (k % 4 == 3) begin
        xx = $urandom_range(0, 8);
        yy = $urandom_range(0, 8);
        w = (grid[xx][yy] + $urandom_range(1, 8)) % SIDE;
        m[idx(xx, yy, 0) +: 9] = '1;
        m[idx(xx, yy, w)] = 1'b0;
      end
      model_run(m, (k % 2) ? 1 : 32, em, eit, es, ec);
      do_run(k % 2, m, 0, cyc, b, mo, it, s, c);
      n_chk++; if (mo !== em) begin n_fail++; $display("FAIL rnd%0d_mask: got %h want %h", k, mo, em); end
      n_chk++; if (it !== 6'(eit) || cyc != eit + 1) begin n_fail++; $display("FAIL rnd%0d_iter: got %0d/%0d want %0d", k, it, cyc, eit); end
      n_chk++; if (s !== es || c !== ec) begin n_fail++; $display("FAIL rnd%0d_flags: got %b%b want %b%b", k, s, c, es, ec); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, eit; bit es, ec; logic b, s, c; logic [5:0] it;
    logic [MW-1:0] mo, em;
    model_run(chain_mask(), 32, em, eit, es, ec);
    do_run(0, chain_mask(), 1, cyc, b, mo, it, s, c);
    n_chk++; if (mo !== em || it !== 6'(eit)) begin n_fail++; $display("FAIL hold_result: got %0d %h want %0d %h", it, mo, eit, em); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (mo0 !== em || cnt0 !== 6'(eit) || sol0 !== es || conf0 !== ec) begin n_fail++; $display("FAIL hold_idle: got %0d %b%b want %0d %b%b", cnt0, sol0, conf0, eit, es, ec); end
    n_chk++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL hold_status: got %b%b want 00", busy0, done0); end
    test_empty();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_solved();
    test_single_open();
    test_row_conflict();
    test_chain_cap();
    test_midrun_reset();
    test_pointing();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
